qpu_instr_encoder: RTL and testbench

Streaming instruction encoder and program loader for the QPU: accepts decoded instruction descriptors over a valid/ready handshake, packs them into 32-bit QPU instruction words using exactly the field layout the EXU decoder unpacks, and writes them sequentially into instruction memory from a programmed base address. It sits between the host/test loader and the ITCM write port, and is the encode side of the QPU instruction format.

---
 rtl/qpu_instr_encoder_pkg.sv | 31 +++
 rtl/qpu_instr_pack.sv | 94 +++++++++
 rtl/qpu_instr_encoder.sv | 154 +++++++++++++++
 tb/tb_qpu_instr_encoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_instr_encoder_pkg.sv
// Shared definitions for the QPU instruction encoder: descriptor kind codes,
// classical opcodes and the signed-immediate range check.
package qpu_instr_encoder_pkg;

   localparam logic [3:0] QPU_ENC_KIND_LOAD    = 4'd0;
   localparam logic [3:0] QPU_ENC_KIND_STORE   = 4'd1;
   localparam logic [3:0] QPU_ENC_KIND_BRANCH  = 4'd2;
   localparam logic [3:0] QPU_ENC_KIND_OPIMM   = 4'd3;
   localparam logic [3:0] QPU_ENC_KIND_OP      = 4'd4;
   localparam logic [3:0] QPU_ENC_KIND_QWAIT   = 4'd5;
   localparam logic [3:0] QPU_ENC_KIND_FMR     = 4'd6;
   localparam logic [3:0] QPU_ENC_KIND_SMIS    = 4'd7;
   localparam logic [3:0] QPU_ENC_KIND_QUANTUM = 4'd8;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_OPIMM  = 5'b00010;
   localparam logic [4:0] OPC_OP     = 5'b01010;
   localparam logic [4:0] OPC_QWAIT  = 5'b10010;
   localparam logic [4:0] OPC_FMR    = 5'b11010;
   localparam logic [4:0] OPC_SMIS   = 5'b00110;

   // True when imm is representable as an n-bit signed value (imm[31:n-1] all equal).
   function automatic logic imm_fits(input logic [31:0] imm, input int unsigned n);
      logic [31:0] sh;
      sh = $signed(imm) >>> (n - 1);
      return (sh == '0) || (sh == '1);
   endfunction

endpackage

// File: rtl/qpu_instr_pack.sv
// Combinational packer: descriptor kind + fields -> 32-bit QPU instruction word,
// flagging out-of-range immediates and undefined kinds.
module qpu_instr_pack
   import qpu_instr_encoder_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [2:0]  func3,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   input  logic [8:0]  qop1,
   input  logic [8:0]  qop2,
   input  logic [2:0]  qpi,
   output logic [31:0] word,
   output logic        range_err
);

   always_comb begin
      word      = '0;
      range_err = 1'b0;
      case (kind)
         QPU_ENC_KIND_LOAD: begin
            word[4:0]   = OPC_LOAD;
            word[9:5]   = rd;
            word[14:10] = rs1;
            word[28:15] = imm[13:0];
            word[31:29] = imm[16:14];
            range_err   = !imm_fits(imm, 17);
         end
         QPU_ENC_KIND_STORE: begin
            word[4:0]   = OPC_STORE;
            word[9:5]   = imm[13:9];
            word[14:10] = rs1;
            word[23:15] = imm[8:0];
            word[28:24] = rs2;
            word[31:29] = imm[16:14];
            range_err   = !imm_fits(imm, 17);
         end
         QPU_ENC_KIND_BRANCH: begin
            word[4:0]   = OPC_BRANCH;
            word[9:5]   = imm[13:9];
            word[14:10] = rs1;
            word[23:15] = imm[8:0];
            word[28:24] = rs2;
            word[31:29] = func3;
            range_err   = !imm_fits(imm, 14);
         end
         QPU_ENC_KIND_OPIMM: begin
            word[4:0]   = OPC_OPIMM;
            word[9:5]   = rd;
            word[14:10] = rs1;
            word[28:15] = imm[13:0];
            word[31:29] = func3;
            range_err   = !imm_fits(imm, 14);
         end
         QPU_ENC_KIND_OP, QPU_ENC_KIND_FMR: begin
            word[4:0]   = (kind == QPU_ENC_KIND_OP) ? OPC_OP : OPC_FMR;
            word[9:5]   = rd;
            word[14:10] = rs1;
            word[28:24] = rs2;
            word[31:29] = func3;
         end
         QPU_ENC_KIND_QWAIT: begin
            // Wait count is scattered across every non-opcode field.
            word[4:0]   = OPC_QWAIT;
            word[9:5]   = imm[23:19];
            word[14:10] = imm[13:9];
            word[23:15] = imm[8:0];
            word[28:24] = imm[18:14];
            word[31:29] = imm[26:24];
            range_err   = !imm_fits(imm, 27);
         end
         QPU_ENC_KIND_SMIS: begin
            word[4:0]   = OPC_SMIS;
            word[9:5]   = rd;
            word[14:10] = imm[13:9];
            word[23:15] = imm[8:0];
            word[31:24] = imm[21:14];
            range_err   = !imm_fits(imm, 22);
         end
         QPU_ENC_KIND_QUANTUM: begin
            word[0]     = 1'b1;
            word[9:1]   = qop1;
            word[14:10] = rs1;
            word[23:15] = qop2;
            word[28:24] = rs2;
            word[31:29] = qpi;
         end
         default: range_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/qpu_instr_encoder.sv
// Streaming instruction encoder / program loader: accepts descriptors, packs
// them and writes the words sequentially into instruction memory.
module qpu_instr_encoder
   import qpu_instr_encoder_pkg::*;
#(
   parameter int unsigned PC_W  = 16,
   parameter int unsigned CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PC_W-1:0]  base_addr,
   input  logic [CNT_W-1:0] word_cnt,
   input  logic             desc_valid,
   output logic             desc_ready,
   input  logic [3:0]       desc_kind,
   input  logic [2:0]       desc_func3,
   input  logic [4:0]       desc_rd,
   input  logic [4:0]       desc_rs1,
   input  logic [4:0]       desc_rs2,
   input  logic [31:0]      desc_imm,
   input  logic [8:0]       desc_qop1,
   input  logic [8:0]       desc_qop2,
   input  logic [2:0]       desc_qpi,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [PC_W-1:0]  mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             enc_err,
   output logic [7:0]       err_cnt
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [PC_W-1:0]  addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             valid_q, valid_d;
   logic             enc_err_q, enc_err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic             zero_done_q, zero_done_d;

   logic [31:0] pack_word;
   logic        pack_err;
   logic        accept;
   logic        write_fire;

   qpu_instr_pack u_pack (
      .kind      (desc_kind),
      .func3     (desc_func3),
      .rd        (desc_rd),
      .rs1       (desc_rs1),
      .rs2       (desc_rs2),
      .imm       (desc_imm),
      .qop1      (desc_qop1),
      .qop2      (desc_qop2),
      .qpi       (desc_qpi),
      .word      (pack_word),
      .range_err (pack_err)
   );

   assign write_fire = valid_q & mem_ready;
   assign desc_ready = (state_q == StRun) & (remain_q != '0) & (~valid_q | mem_ready);
   assign accept     = desc_valid & desc_ready;

   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      valid_d     = valid_q;
      enc_err_d   = 1'b0;
      err_cnt_d   = err_cnt_q;
      zero_done_d = 1'b0;

      // mem_addr always names the held word; the next word goes one slot later.
      if (write_fire) begin
         valid_d = 1'b0;
         addr_d  = addr_q + PC_W'(4);
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               addr_d    = base_addr & ~PC_W'(3);
               remain_d  = word_cnt;
               err_cnt_d = '0;
               if (word_cnt == '0) begin
                  zero_done_d = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (accept) begin
               remain_d = remain_q - CNT_W'(1);
               if (remain_q == CNT_W'(1)) begin
                  state_d = StDrain;
               end
               if (pack_err) begin
                  enc_err_d = 1'b1;
                  if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end else begin
                  valid_d = 1'b1;
                  wdata_d = pack_word;
               end
            end
         end
         StDrain: begin
            if (!valid_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         remain_q    <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         valid_q     <= 1'b0;
         enc_err_q   <= 1'b0;
         err_cnt_q   <= '0;
         zero_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         valid_q     <= valid_d;
         enc_err_q   <= enc_err_d;
         err_cnt_q   <= err_cnt_d;
         zero_done_q <= zero_done_d;
      end
   end

   assign mem_valid = valid_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != StIdle);
   assign done      = ((state_q == StDrain) & ~valid_q) | zero_done_q;
   assign enc_err   = enc_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_qpu_instr_encoder.sv
// Scoreboard bench for qpu_instr_encoder: directed descriptors push expected
// {addr, data} entries; a negedge monitor checks every memory write.
module tb_qpu_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [11:0] word_cnt;
   logic        desc_valid;
   logic        desc_ready;
   logic [3:0]  desc_kind;
   logic [2:0]  desc_func3;
   logic [4:0]  desc_rd, desc_rs1, desc_rs2;
   logic [31:0] desc_imm;
   logic [8:0]  desc_qop1, desc_qop2;
   logic [2:0]  desc_qpi;
   logic        mem_valid;
   logic        mem_ready;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, done, enc_err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int failures = 0;
   int writes_seen = 0;
   int err_seen = 0;
   int done_seen = 0;
   int exp_err = 0;
   logic [15:0] exp_addr;
   logic [47:0] exp_q[$];

   qpu_instr_encoder #(.PC_W(16), .CNT_W(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_cnt   (word_cnt),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_kind  (desc_kind),
      .desc_func3 (desc_func3),
      .desc_rd    (desc_rd),
      .desc_rs1   (desc_rs1),
      .desc_rs2   (desc_rs2),
      .desc_imm   (desc_imm),
      .desc_qop1  (desc_qop1),
      .desc_qop2  (desc_qop2),
      .desc_qpi   (desc_qpi),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .enc_err    (enc_err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: scoreboard pops on each completed write; held words must not change.
   initial begin
      logic        held_v;
      logic [15:0] held_addr;
      logic [31:0] held_data;
      logic [47:0] e;
      held_v = 1'b0;
      held_addr = '0;
      held_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            held_v = 1'b0;
         end else begin
            if (held_v && mem_valid) begin
               check("hold_addr", 64'(mem_addr), 64'(held_addr));
               check("hold_data", 64'(mem_wdata), 64'(held_data));
            end
            if (mem_valid && mem_ready) begin
               writes_seen++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_write actual=%0h:%0h required=none",
                           mem_addr, mem_wdata);
               end else begin
                  e = exp_q.pop_front();
                  check("wr_addr", 64'(mem_addr), 64'(e[47:32]));
                  check("wr_data", 64'(mem_wdata), 64'(e[31:0]));
               end
            end
            held_v    = mem_valid && !mem_ready;
            held_addr = mem_addr;
            held_data = mem_wdata;
            if (enc_err) err_seen++;
            if (done) done_seen++;
         end
      end
   end

   task automatic start_session(input logic [15:0] base, input logic [11:0] cnt);
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = base;
      word_cnt  = cnt;
      exp_addr  = base & 16'hFFFC;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                       input logic [8:0] q1, input logic [8:0] q2, input logic [2:0] pi,
                       input logic bad, input logic [31:0] exp_word);
      int n;
      desc_kind  = k;
      desc_func3 = f3;
      desc_rd    = rd;
      desc_rs1   = rs1;
      desc_rs2   = rs2;
      desc_imm   = imm;
      desc_qop1  = q1;
      desc_qop2  = q2;
      desc_qpi   = pi;
      desc_valid = 1'b1;
      if (bad) begin
         exp_err++;
      end else begin
         exp_q.push_back({exp_addr, exp_word});
         exp_addr = exp_addr + 16'd4;
      end
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (desc_ready) break;
      end
      if (n == 100) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=no_ready required=ready");
      end
      @(posedge clk);
      #1;
      desc_valid = 1'b0;
   endtask

   task automatic wait_done();
      int d0;
      int n;
      d0 = done_seen;
      for (n = 0; n < 200; n++) begin
         @(posedge clk);
         if (done_seen != d0) break;
      end
      check("done_pulse", 64'(done_seen != d0), 64'd1);
   endtask

   initial begin
      int w0;
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = '0;
      word_cnt = '0;
      desc_valid = 1'b0;
      desc_kind = '0;
      desc_func3 = '0;
      desc_rd = '0;
      desc_rs1 = '0;
      desc_rs2 = '0;
      desc_imm = '0;
      desc_qop1 = '0;
      desc_qop2 = '0;
      desc_qpi = '0;
      mem_ready = 1'b1;
      exp_addr = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_desc_ready", 64'(desc_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_enc_err", 64'(enc_err), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      rst_n = 1'b1;

      // OPIMM rd=3 rs1=1 imm=5
      start_session(16'h0100, 12'd1);
      send(4'd3, 3'd0, 5'd3, 5'd1, 5'd0, 32'd5, 9'd0, 9'd0, 3'd0, 1'b0, 32'h0002_8462);
      wait_done();
      check("t1_err_cnt", 64'(err_cnt), 64'd0);

      // QUANTUM and BRANCH imm=-4
      start_session(16'h0200, 12'd2);
      send(4'd8, 3'd0, 5'd0, 5'd2, 5'd0, 32'd0, 9'h1FF, 9'd0, 3'd1, 1'b0, 32'h2000_0BFF);
      send(4'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 9'd0, 9'd0, 3'd0, 1'b0, 32'h02FE_07F8);
      wait_done();

      // OPIMM rejection inside a 3-word session; third uses the N=14 minimum
      w0 = writes_seen;
      start_session(16'h0300, 12'd3);
      send(4'd3, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0, 9'd0, 9'd0, 3'd0, 1'b0, 32'h0000_0022);
      send(4'd3, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_2000, 9'd0, 9'd0, 3'd0, 1'b1, 32'h0);
      send(4'd3, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_E000, 9'd0, 9'd0, 3'd0, 1'b0, 32'h1000_0002);
      wait_done();
      check("t3_err_cnt", 64'(err_cnt), 64'd1);
      check("t3_writes", 64'(writes_seen - w0), 64'd2);

      // 4-word burst with mem_ready low for 3 cycles
      w0 = writes_seen;
      start_session(16'h0400, 12'd4);
      fork
         begin
            send(4'd0, 3'd0, 5'd2, 5'd4, 5'd0, 32'hFFFF_FFFF, 9'd0, 9'd0, 3'd0, 1'b0,
                 32'hFFFF_9040);
            send(4'd1, 3'd0, 5'd0, 5'd3, 5'd4, 32'hFFFF_0000, 9'd0, 9'd0, 3'd0, 1'b0,
                 32'h8400_0C08);
            send(4'd4, 3'd2, 5'd5, 5'd6, 5'd7, 32'd0, 9'd0, 9'd0, 3'd0, 1'b0, 32'h4700_18AA);
            send(4'd5, 3'd0, 5'd0, 5'd0, 5'd0, 32'h03FF_FFFF, 9'd0, 9'd0, 3'd0, 1'b0,
                 32'h7FFF_FFF2);
         end
         begin
            repeat (2) @(posedge clk);
            #1 mem_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 mem_ready = 1'b1;
         end
      join
      wait_done();
      check("t4_writes", 64'(writes_seen - w0), 64'd4);
      check("t4_err_cnt", 64'(err_cnt), 64'd0);

      // Address wrap, unaligned base, undefined kind and QWAIT just out of range
      start_session(16'hFFFE, 12'd4);
      send(4'd7, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0015, 9'd0, 9'd0, 3'd0, 1'b0, 32'h000A_8026);
      send(4'd6, 3'd0, 5'd1, 5'd2, 5'd0, 32'h1234_5678, 9'd0, 9'd0, 3'd0, 1'b0, 32'h0000_083A);
      send(4'd9, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 9'd0, 9'd0, 3'd0, 1'b1, 32'h0);
      send(4'd5, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0400_0000, 9'd0, 9'd0, 3'd0, 1'b1, 32'h0);
      wait_done();
      check("t5_err_cnt", 64'(err_cnt), 64'd2);

      // Zero-length session
      start_session(16'h0600, 12'd0);
      wait_done();
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_err_cnt", 64'(err_cnt), 64'd0);

      // Reset with a word pending in the output register
      start_session(16'h0500, 12'd2);
      mem_ready = 1'b0;
      send(4'd3, 3'd0, 5'd3, 5'd1, 5'd0, 32'd5, 9'd0, 9'd0, 3'd0, 1'b0, 32'h0002_8462);
      @(negedge clk);
      check("t7_pending", 64'(mem_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t7_rst_valid", 64'(mem_valid), 64'd0);
      check("t7_rst_busy", 64'(busy), 64'd0);
      check("t7_rst_ready", 64'(desc_ready), 64'd0);
      void'(exp_q.pop_back());
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      w0 = writes_seen;
      repeat (5) @(posedge clk);
      check("t7_no_write", 64'(writes_seen - w0), 64'd0);
      check("t7_idle", 64'(busy), 64'd0);

      check("enc_err_pulses", 64'(err_seen), 64'(exp_err));
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
